// File: rtl/ex_stage_mc.sv
// Execute stage: single-cycle ALU/branch resolution with a registered, handshaked result.
// Define EX_MULDIV_EN to add the iterative radix-2 MUL/MULHU/DIVU/REMU unit (XLEN+1 cycle latency).
module ex_stage_mc #(
  parameter int XLEN    = 32,
  parameter int RADDR_W = 5
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               id_ex_reg_valid_i,
  output logic               ex_ready_o,
  input  logic [XLEN-1:0]    id_ex_reg_op_a_i,
  input  logic [XLEN-1:0]    id_ex_reg_op_b_i,
  input  logic [4:0]         id_ex_reg_ALUctrl_i,
  input  logic [RADDR_W-1:0] id_ex_reg_reg_waddr_i,
  input  logic               id_ex_reg_reg_we_i,
  input  logic               id_ex_reg_btype_i,
  input  logic [XLEN-1:0]    id_ex_reg_next_pc_i,
  input  logic               ex_kill_i,
  output logic               ex_valid_o,
  input  logic               ex_mem_ready_i,
  output logic [XLEN-1:0]    ex_op_c_o,
  output logic [RADDR_W-1:0] ex_reg_waddr_o,
  output logic               ex_reg_we_o,
  output logic               ex_branch_o,
  output logic               ex_ins_flush_o,
  output logic [XLEN-1:0]    ex_next_pc_o
);

  localparam int SHW = $clog2(XLEN);

  localparam logic [4:0] OP_ADD   = 5'd0;
  localparam logic [4:0] OP_SUB   = 5'd1;
  localparam logic [4:0] OP_SLL   = 5'd2;
  localparam logic [4:0] OP_SRL   = 5'd3;
  localparam logic [4:0] OP_SRA   = 5'd4;
  localparam logic [4:0] OP_EQU   = 5'd5;
  localparam logic [4:0] OP_NEQ   = 5'd6;
  localparam logic [4:0] OP_SLT   = 5'd7;
  localparam logic [4:0] OP_SGE   = 5'd8;
  localparam logic [4:0] OP_SLTU  = 5'd9;
  localparam logic [4:0] OP_SGEU  = 5'd10;
  localparam logic [4:0] OP_XOR   = 5'd11;
  localparam logic [4:0] OP_OR    = 5'd12;
  localparam logic [4:0] OP_AND   = 5'd13;
  localparam logic [4:0] OP_NO_OP = 5'd14;
  localparam logic [4:0] OP_MUL   = 5'd16;
  localparam logic [4:0] OP_MULHU = 5'd17;
  localparam logic [4:0] OP_DIVU  = 5'd18;
  localparam logic [4:0] OP_REMU  = 5'd19;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_HOLD = 2'd1;
`ifdef EX_MULDIV_EN
  localparam logic [1:0] ST_BUSY = 2'd2;
  localparam int         CNT_W   = $clog2(XLEN + 1);
`endif

  logic [1:0]         state_q, state_d;
  logic               valid_q, we_q, branch_q;
  logic [XLEN-1:0]    op_c_q, next_pc_q;
  logic [RADDR_W-1:0] waddr_q;

  logic               accept, is_md, drain;
  logic [XLEN-1:0]    alu_res;
  logic [SHW-1:0]     shamt;

  // ---------------- single-cycle ALU ----------------
  assign shamt = id_ex_reg_op_b_i[SHW-1:0];

  always_comb begin
    alu_res = '0;
    case (id_ex_reg_ALUctrl_i)
      OP_ADD:  alu_res = id_ex_reg_op_a_i + id_ex_reg_op_b_i;
      OP_SUB:  alu_res = id_ex_reg_op_a_i - id_ex_reg_op_b_i;
      OP_SLL:  alu_res = id_ex_reg_op_a_i << shamt;
      OP_SRL:  alu_res = id_ex_reg_op_a_i >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(id_ex_reg_op_a_i) >>> shamt);
      OP_EQU:  alu_res = {{(XLEN-1){1'b0}}, id_ex_reg_op_a_i == id_ex_reg_op_b_i};
      OP_NEQ:  alu_res = {{(XLEN-1){1'b0}}, id_ex_reg_op_a_i != id_ex_reg_op_b_i};
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(id_ex_reg_op_a_i) <  $signed(id_ex_reg_op_b_i)};
      OP_SGE:  alu_res = {{(XLEN-1){1'b0}}, $signed(id_ex_reg_op_a_i) >= $signed(id_ex_reg_op_b_i)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, id_ex_reg_op_a_i <  id_ex_reg_op_b_i};
      OP_SGEU: alu_res = {{(XLEN-1){1'b0}}, id_ex_reg_op_a_i >= id_ex_reg_op_b_i};
      OP_XOR:  alu_res = id_ex_reg_op_a_i ^ id_ex_reg_op_b_i;
      OP_OR:   alu_res = id_ex_reg_op_a_i | id_ex_reg_op_b_i;
      OP_AND:  alu_res = id_ex_reg_op_a_i & id_ex_reg_op_b_i;
      // Mul/div codes resolve to zero here; the iterative unit supplies them when present.
      OP_NO_OP, OP_MUL, OP_MULHU, OP_DIVU, OP_REMU: alu_res = '0;
      default: alu_res = '0;
    endcase
  end

`ifdef EX_MULDIV_EN
  assign is_md = (id_ex_reg_ALUctrl_i[4:2] == 3'b100);
`else
  assign is_md = 1'b0;
`endif

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

`ifdef EX_MULDIV_EN
  logic [CNT_W-1:0] cnt_q;
  logic             iterate, finalize;
`endif

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    if (ex_kill_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: if (accept) state_d = is_md ? 2'd2 : ST_HOLD;
        ST_HOLD: if (ex_mem_ready_i) state_d = accept ? (is_md ? 2'd2 : ST_HOLD) : ST_IDLE;
`ifdef EX_MULDIV_EN
        ST_BUSY: if (finalize) state_d = ST_HOLD;
`endif
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // ---------------- FSM: outputs / strobes ----------------
  always_comb begin
    ex_ready_o = !ex_kill_i &&
                 ((state_q == ST_IDLE) || ((state_q == ST_HOLD) && ex_mem_ready_i));
    accept     = id_ex_reg_valid_i && ex_ready_o;
    drain      = (state_q == ST_HOLD) && ex_mem_ready_i;
`ifdef EX_MULDIV_EN
    iterate    = (state_q == ST_BUSY) && (cnt_q != '0);
    finalize   = (state_q == ST_BUSY) && (cnt_q == '0);
`endif
  end

`ifdef EX_MULDIV_EN
  // ---------------- iterative radix-2 mul/div ----------------
  // hi/lo hold {partial product, multiplier} for MUL, {remainder, quotient} for DIV.
  logic [XLEN-1:0] hi_q, lo_q, b_q;
  logic [1:0]      mdop_q;
  logic            we_pend_q, btype_q;
  logic [XLEN:0]   mul_sum, div_sh;
  logic            div_ge;
  logic [XLEN-1:0] md_res;

  assign mul_sum = {1'b0, hi_q} + {1'b0, (lo_q[0] ? b_q : {XLEN{1'b0}})};
  assign div_sh  = {hi_q, lo_q[XLEN-1]};
  assign div_ge  = div_sh >= {1'b0, b_q};
  assign md_res  = mdop_q[0] ? hi_q : lo_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q      <= '0;
      lo_q      <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      mdop_q    <= '0;
      we_pend_q <= 1'b0;
      btype_q   <= 1'b0;
    end else if (accept && is_md) begin
      hi_q      <= '0;
      lo_q      <= id_ex_reg_op_a_i;
      b_q       <= id_ex_reg_op_b_i;
      cnt_q     <= CNT_W'(XLEN);
      mdop_q    <= id_ex_reg_ALUctrl_i[1:0];
      we_pend_q <= id_ex_reg_reg_we_i;
      btype_q   <= id_ex_reg_btype_i;
    end else if (iterate) begin
      cnt_q <= cnt_q - 1'b1;
      if (!mdop_q[1]) begin
        hi_q <= mul_sum[XLEN:1];
        lo_q <= {mul_sum[0], lo_q[XLEN-1:1]};
      end else begin
        // A zero divisor always subtracts, leaving all-ones quotient and op_a as remainder.
        hi_q <= div_ge ? (div_sh[XLEN-1:0] - b_q) : div_sh[XLEN-1:0];
        lo_q <= {lo_q[XLEN-2:0], div_ge};
      end
    end
  end
`endif

  // ---------------- registered result ----------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q   <= 1'b0;
      we_q      <= 1'b0;
      branch_q  <= 1'b0;
      op_c_q    <= '0;
      next_pc_q <= '0;
      waddr_q   <= '0;
    end else begin
      branch_q <= 1'b0;
      if (ex_kill_i) begin
        valid_q <= 1'b0;
        we_q    <= 1'b0;
      end else if (accept && !is_md) begin
        valid_q   <= 1'b1;
        op_c_q    <= alu_res;
        waddr_q   <= id_ex_reg_reg_waddr_i;
        we_q      <= id_ex_reg_reg_we_i;
        next_pc_q <= id_ex_reg_next_pc_i;
        branch_q  <= id_ex_reg_btype_i && (alu_res != '0);
`ifdef EX_MULDIV_EN
      end else if (accept) begin
        valid_q   <= 1'b0;
        we_q      <= 1'b0;
        waddr_q   <= id_ex_reg_reg_waddr_i;
        next_pc_q <= id_ex_reg_next_pc_i;
      end else if (finalize) begin
        valid_q  <= 1'b1;
        op_c_q   <= md_res;
        we_q     <= we_pend_q;
        branch_q <= btype_q && (md_res != '0);
`endif
      end else if (drain) begin
        valid_q <= 1'b0;
        we_q    <= 1'b0;
      end
    end
  end

  assign ex_valid_o     = valid_q;
  assign ex_op_c_o      = op_c_q;
  assign ex_reg_waddr_o = waddr_q;
  assign ex_reg_we_o    = we_q;
  assign ex_branch_o    = branch_q;
  assign ex_ins_flush_o = branch_q;
  assign ex_next_pc_o   = next_pc_q;

endmodule

// File: tb/tb_ex_stage_mc.sv
// Randomised scoreboard bench for ex_stage_mc; the reference model follows the
// EX_MULDIV_EN setting used for the build.
module tb_ex_stage_mc;
  localparam int XLEN    = 32;
  localparam int RADDR_W = 5;
  localparam int SHW     = $clog2(XLEN);

  logic               clk = 1'b0;
  logic               rst_n = 1'b0;
  logic               valid_i = 1'b0, ready_o;
  logic [XLEN-1:0]    op_a = '0, op_b = '0, next_pc = '0;
  logic [4:0]         aluctrl = '0;
  logic [RADDR_W-1:0] waddr = '0;
  logic               we = 1'b0, btype = 1'b0, kill = 1'b0, mem_ready = 1'b1;
  logic               valid_o, we_o, branch_o, flush_o;
  logic [XLEN-1:0]    op_c_o, next_pc_o;
  logic [RADDR_W-1:0] waddr_o;

  always #5 clk = ~clk;

  ex_stage_mc #(.XLEN(XLEN), .RADDR_W(RADDR_W)) dut (
    .clk(clk), .rst_n(rst_n),
    .id_ex_reg_valid_i(valid_i), .ex_ready_o(ready_o),
    .id_ex_reg_op_a_i(op_a), .id_ex_reg_op_b_i(op_b),
    .id_ex_reg_ALUctrl_i(aluctrl), .id_ex_reg_reg_waddr_i(waddr),
    .id_ex_reg_reg_we_i(we), .id_ex_reg_btype_i(btype),
    .id_ex_reg_next_pc_i(next_pc), .ex_kill_i(kill),
    .ex_valid_o(valid_o), .ex_mem_ready_i(mem_ready),
    .ex_op_c_o(op_c_o), .ex_reg_waddr_o(waddr_o), .ex_reg_we_o(we_o),
    .ex_branch_o(branch_o), .ex_ins_flush_o(flush_o), .ex_next_pc_o(next_pc_o)
  );

  typedef struct {
    logic [XLEN-1:0]    c;
    logic [XLEN-1:0]    pc;
    logic [RADDR_W-1:0] wa;
    logic               we;
    logic               br;
    logic [4:0]         op;
    int                 acc;
    int                 lat;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0, n_bad = 0, cyc = 0, n_txn = 0, mr_mode = 0;
  bit   head_shown = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference behaviour straight from the operation definitions.
  function automatic logic [XLEN-1:0] ref_c(input logic [4:0] op, input logic [XLEN-1:0] a,
                                            input logic [XLEN-1:0] b);
    logic [2*XLEN-1:0] p;
    logic [SHW-1:0]    sh;
    logic [XLEN-1:0]   r;
    sh = b[SHW-1:0];
    p  = {{XLEN{1'b0}}, a} * {{XLEN{1'b0}}, b};
    r  = '0;
    case (op)
      5'd0:  r = a + b;
      5'd1:  r = a - b;
      5'd2:  r = a << sh;
      5'd3:  r = a >> sh;
      5'd4:  r = $signed(a) >>> sh;
      5'd5:  r = (a == b) ? 1 : 0;
      5'd6:  r = (a != b) ? 1 : 0;
      5'd7:  r = ($signed(a) <  $signed(b)) ? 1 : 0;
      5'd8:  r = ($signed(a) >= $signed(b)) ? 1 : 0;
      5'd9:  r = (a <  b) ? 1 : 0;
      5'd10: r = (a >= b) ? 1 : 0;
      5'd11: r = a ^ b;
      5'd12: r = a | b;
      5'd13: r = a & b;
`ifdef EX_MULDIV_EN
      5'd16: r = p[XLEN-1:0];
      5'd17: r = p[2*XLEN-1:XLEN];
      5'd18: r = (b == 0) ? '1 : a / b;
      5'd19: r = (b == 0) ? a : a % b;
`endif
      default: r = '0;
    endcase
    return r;
  endfunction

  function automatic int ref_lat(input logic [4:0] op);
`ifdef EX_MULDIV_EN
    if (op >= 5'd16 && op <= 5'd19) return XLEN + 1;
`endif
    return 1;
  endfunction

  // Stimulus side of the scoreboard: record the expectation of every accepted op.
  always begin
    exp_t e;
    @(negedge clk);
    #1;
    if (rst_n && valid_i && ready_o && !kill) begin
      e.c   = ref_c(aluctrl, op_a, op_b);
      e.pc  = next_pc;
      e.wa  = waddr;
      e.we  = we;
      e.br  = btype && (e.c != '0);
      e.op  = aluctrl;
      e.acc = cyc;
      e.lat = ref_lat(aluctrl);
      q.push_back(e);
    end
  end

  // Monitor: compares whatever the DUT presents against the queue head.
  always @(negedge clk) begin
    logic exp_ready;
    if (!rst_n) begin
      q.delete();
      head_shown = 1'b0;
      chk("rst_valid", valid_o, 0);
      chk("rst_op_c", op_c_o, 0);
      chk("rst_branch", branch_o, 0);
      chk("rst_flush", flush_o, 0);
      chk("rst_we", we_o, 0);
      chk("rst_waddr", waddr_o, 0);
      chk("rst_next_pc", next_pc_o, 0);
    end else begin
      exp_ready = !kill && (q.size() == 0 || (cyc >= q[0].acc + q[0].lat && mem_ready));
      chk("ready", ready_o, exp_ready);
      if (kill) begin
        q.delete();
        head_shown = 1'b0;
      end else if (valid_o) begin
        if (q.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL spurious_valid: got valid=1 op_c=%h want no result (cycle %0d)", op_c_o, cyc);
        end else begin
          if (!head_shown) chk("latency", cyc - q[0].acc, q[0].lat);
          chk("op_c", op_c_o, q[0].c);
          chk("waddr", waddr_o, q[0].wa);
          chk("we", we_o, q[0].we);
          chk("next_pc", next_pc_o, q[0].pc);
          chk("branch", branch_o, !head_shown && q[0].br);
          chk("flush", flush_o, !head_shown && q[0].br);
          head_shown = 1'b1;
          if (mem_ready) begin
            n_txn++;
            $display("txn %0d op=%0d c=%h wa=%0d br=%0b", n_txn, q[0].op, op_c_o, waddr_o, q[0].br);
            void'(q.pop_front());
            head_shown = 1'b0;
          end
        end
      end else begin
        chk("idle_we", we_o, 0);
        chk("idle_branch", branch_o, 0);
        if (q.size() > 0 && cyc > q[0].acc + q[0].lat) begin
          n_cmp++; n_bad++;
          $display("FAIL late_result: got valid=0 want valid after %0d cycles (cycle %0d)", q[0].lat, cyc);
          void'(q.pop_front());
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
    case (mr_mode)
      0:       mem_ready = 1'b1;
      1:       mem_ready = ($urandom_range(0, 2) != 0);
      default: mem_ready = 1'b0;
    endcase
  endtask

  task automatic send(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                      input logic bt, input logic [XLEN-1:0] pc);
    bit ok;
    ok      = 1'b0;
    valid_i = 1'b1;
    aluctrl = op;
    op_a    = a;
    op_b    = b;
    btype   = bt;
    next_pc = pc;
    waddr   = RADDR_W'($urandom);
    we      = 1'($urandom);
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (valid_i && ready_o && !kill) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    if (!ok) begin
      n_cmp++; n_bad++;
      $display("FAIL accept_timeout: got ready=0 for 200 cycles want accept of op %0d", op);
    end
    step();
    valid_i = 1'b0;
    // Scramble the inputs so a stage that fails to capture at accept is exposed.
    op_a    = $urandom;
    op_b    = $urandom;
    aluctrl = 5'($urandom);
    btype   = 1'($urandom);
    next_pc = $urandom;
  endtask

  initial begin
    logic [4:0]      op;
    logic [XLEN-1:0] a, b;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    step();

    // ADD then back-to-back SUB with the sink always ready.
    mr_mode = 0;
    send(5'd0, 5, 7, 1'b0, 0);
    send(5'd1, 3, 5, 1'b0, 0);
    step();

    // Taken branch held for three cycles: flush must pulse once.
    mr_mode = 2;
    send(5'd7, '1, 1, 1'b1, 32'h80);
    repeat (2) step();
    mr_mode = 0;
    step();

    // Mul/div corner values.
    send(5'd16, 32'hFFFF, 32'hFFFF, 1'b0, 0);
    send(5'd17, '1, '1, 1'b0, 0);
    send(5'd18, 100, 0, 1'b0, 0);
    send(5'd19, 100, 0, 1'b0, 0);
    send(5'd18, 100, 7, 1'b0, 0);
    send(5'd19, 100, 7, 1'b0, 0);
    send(5'd16, 3, 4, 1'b1, 32'h44);
    send(5'd4, 32'h8000_0000, 31, 1'b0, 0);
    send(5'd15, 9, 9, 1'b1, 0);
    step();

    // Kill around iteration 10, then a fresh ADD.
    send(5'd18, 100, 7, 1'b0, 0);
    repeat (9) step();
    kill = 1'b1;
    mem_ready = 1'b0;
    step();
    kill = 1'b0;
    send(5'd0, 1, 1, 1'b0, 0);
    step();

    // Asynchronous reset in the middle of an iteration.
    send(5'd19, 12345, 67, 1'b0, 0);
    repeat (4) step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    send(5'd12, 32'hF0, 32'h0F, 1'b0, 0);

    // Random traffic with a randomly stalling sink.
    for (int n = 0; n < 150; n++) begin
      mr_mode = ($urandom_range(0, 3) == 0) ? 0 : 1;
      op = 5'($urandom_range(0, 24));
      a  = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 15)) : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? XLEN'($urandom_range(0, 15)) : $urandom;
      send(op, a, b, 1'($urandom), $urandom);
      if ($urandom_range(0, 1) == 0) step();
    end

    mr_mode = 0;
    repeat (XLEN + 5) step();
    @(negedge clk);
    chk("queue_drained", XLEN'(q.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
